// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller: FSM state encoding,
// seven-segment patterns (active-low, gfedcba) and a BCD conversion helper.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } sw_state_e;

    localparam int MAX_DIGITS = 8;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Elaboration-time conversion of a binary constant into packed BCD digits.
    function automatic logic [4*MAX_DIGITS-1:0] int_to_bcd(input int value);
        logic [4*MAX_DIGITS-1:0] bcd;
        int                      v;
        bcd = '0;
        v   = value;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            bcd[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return bcd;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_seg7_decode.sv
// Combinational BCD-to-seven-segment decoder with a blanking override.
// Non-decimal codes are shown blank.
module seg7_decode
    import stopwatch_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (bcd)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: prescaled BCD counter with start/pause/clear, optional
// target time with a timed DONE state, and registered seven-segment output.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_PER_TICK = 10,
    parameter int NUM_DIGITS   = 4,
    parameter int TARGET       = 5,
    parameter int DONE_TICKS   = 1,
    parameter int LZ_BLANK     = 0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i_start,
    input  logic                    i_pause,
    input  logic                    i_clear,
    output logic                    o_idle,
    output logic                    o_running,
    output logic                    o_paused,
    output logic                    o_done,
    output logic                    o_tick,
    output logic [4*NUM_DIGITS-1:0] o_bcd,
    output logic [7*NUM_DIGITS-1:0] o_seg
);

    localparam int BW = 4 * NUM_DIGITS;
    localparam int SW = 7 * NUM_DIGITS;
    localparam int PW = $clog2(CLK_PER_TICK);
    localparam int DW = (DONE_TICKS > 1) ? $clog2(DONE_TICKS) : 1;

    localparam logic [4*MAX_DIGITS-1:0] TARGET_BCD_FULL = int_to_bcd(TARGET);
    localparam logic [BW-1:0]           TARGET_BCD      = TARGET_BCD_FULL[BW-1:0];

    sw_state_e       state_reg, state_next;
    logic [PW-1:0]   presc_reg, presc_next;
    logic [BW-1:0]   count_reg, count_next;
    logic [DW-1:0]   done_cnt_reg, done_cnt_next;
    logic            tick_reg, tick_next;
    logic [SW-1:0]   seg_reg;

    logic [BW-1:0]         count_inc;
    logic [NUM_DIGITS-1:0] carry_in;
    logic [NUM_DIGITS:0]   upper_zero;
    logic [NUM_DIGITS-1:0] blank;
    logic [SW-1:0]         seg_dec;

    logic          wrap;
    logic [PW-1:0] presc_adv;
    logic          hit_target;

    assign carry_in[0]            = 1'b1;
    assign upper_zero[NUM_DIGITS] = 1'b1;

    // Per-digit BCD increment (ripple carry) and leading-zero detection.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        logic [3:0] digit;
        assign digit = count_reg[4*gi +: 4];

        assign count_inc[4*gi +: 4] = carry_in[gi] ? ((digit == 4'd9) ? 4'd0 : digit + 4'd1)
                                                   : digit;
        if (gi < NUM_DIGITS - 1) begin : g_carry
            assign carry_in[gi+1] = carry_in[gi] & (digit == 4'd9);
        end

        assign upper_zero[gi] = (digit == 4'd0) & upper_zero[gi+1];
        assign blank[gi]      = (LZ_BLANK != 0) && (gi != 0) && upper_zero[gi];

        seg7_decode u_seg7_decode (
            .bcd   (digit),
            .blank (blank[gi]),
            .seg   (seg_dec[7*gi +: 7])
        );
    end

    assign wrap       = (presc_reg == PW'(CLK_PER_TICK - 1));
    assign presc_adv  = wrap ? '0 : presc_reg + PW'(1);
    assign hit_target = (TARGET != 0) && (count_inc == TARGET_BCD);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            presc_reg    <= '0;
            count_reg    <= '0;
            done_cnt_reg <= '0;
            tick_reg     <= 1'b0;
            seg_reg      <= '1;
        end else begin
            state_reg    <= state_next;
            presc_reg    <= presc_next;
            count_reg    <= count_next;
            done_cnt_reg <= done_cnt_next;
            tick_reg     <= tick_next;
            seg_reg      <= seg_dec;
        end
    end

    always_comb begin
        state_next    = state_reg;
        presc_next    = presc_reg;
        count_next    = count_reg;
        done_cnt_next = done_cnt_reg;
        tick_next     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (i_clear) begin
                    count_next = '0;
                end else if (i_start) begin
                    state_next = ST_RUN;
                    count_next = '0;
                    presc_next = '0;
                end
            end

            ST_RUN: begin
                if (i_clear) begin
                    state_next = ST_IDLE;
                    count_next = '0;
                    presc_next = '0;
                end else if (i_start) begin
                    count_next = '0;
                    presc_next = '0;
                end else begin
                    presc_next = presc_adv;
                    if (wrap) begin
                        tick_next  = 1'b1;
                        count_next = count_inc;
                    end
                    // Reaching the target wins over a pause in the same cycle.
                    if (wrap && hit_target) begin
                        state_next    = ST_DONE;
                        done_cnt_next = '0;
                    end else if (i_pause) begin
                        state_next = ST_PAUSE;
                    end
                end
            end

            ST_PAUSE: begin
                if (i_clear) begin
                    state_next = ST_IDLE;
                    count_next = '0;
                    presc_next = '0;
                end else if (i_start) begin
                    state_next = ST_RUN;
                    count_next = '0;
                    presc_next = '0;
                end else if (i_pause) begin
                    state_next = ST_RUN;
                end
            end

            ST_DONE: begin
                if (i_clear) begin
                    state_next = ST_IDLE;
                    count_next = '0;
                    presc_next = '0;
                end else if (i_start) begin
                    state_next = ST_RUN;
                    count_next = '0;
                    presc_next = '0;
                end else begin
                    presc_next = presc_adv;
                    if (wrap) begin
                        tick_next = 1'b1;
                        if (done_cnt_reg == DW'(DONE_TICKS - 1)) begin
                            state_next = ST_IDLE;
                        end else begin
                            done_cnt_next = done_cnt_reg + DW'(1);
                        end
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign o_idle    = (state_reg == ST_IDLE);
    assign o_running = (state_reg == ST_RUN);
    assign o_paused  = (state_reg == ST_PAUSE);
    assign o_done    = (state_reg == ST_DONE);
    assign o_tick    = tick_reg;
    assign o_bcd     = count_reg;
    assign o_seg     = seg_reg;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: a tick scoreboard on the default
// instance plus directed checks on free-run and leading-zero-blank instances.
module tb_stopwatch_ctrl;
    import stopwatch_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    // Instance A: default parameters.
    logic        start_a, pause_a, clear_a;
    logic        idle_a, running_a, paused_a, done_a, tick_a;
    logic [15:0] bcd_a;
    logic [27:0] seg_a;
    logic [3:0]  flags_a;
    assign flags_a = {idle_a, running_a, paused_a, done_a};

    // Instance B: free-run, two digits, fast prescaler.
    logic        start_b, pause_b, clear_b;
    logic        idle_b, running_b, paused_b, done_b, tick_b;
    logic [7:0]  bcd_b;
    logic [13:0] seg_b;

    // Instance C: as B but with leading-zero blanking.
    logic        start_c, pause_c, clear_c;
    logic        idle_c, running_c, paused_c, done_c, tick_c;
    logic [7:0]  bcd_c;
    logic [13:0] seg_c;

    localparam logic [3:0] F_IDLE  = 4'b1000;
    localparam logic [3:0] F_RUN   = 4'b0100;
    localparam logic [3:0] F_PAUSE = 4'b0010;
    localparam logic [3:0] F_DONE  = 4'b0001;

    stopwatch_ctrl #(
        .CLK_PER_TICK(10), .NUM_DIGITS(4), .TARGET(5), .DONE_TICKS(1), .LZ_BLANK(0)
    ) u_dut_a (
        .clk(clk), .reset_n(reset_n),
        .i_start(start_a), .i_pause(pause_a), .i_clear(clear_a),
        .o_idle(idle_a), .o_running(running_a), .o_paused(paused_a), .o_done(done_a),
        .o_tick(tick_a), .o_bcd(bcd_a), .o_seg(seg_a)
    );

    stopwatch_ctrl #(
        .CLK_PER_TICK(2), .NUM_DIGITS(2), .TARGET(0), .DONE_TICKS(1), .LZ_BLANK(0)
    ) u_dut_b (
        .clk(clk), .reset_n(reset_n),
        .i_start(start_b), .i_pause(pause_b), .i_clear(clear_b),
        .o_idle(idle_b), .o_running(running_b), .o_paused(paused_b), .o_done(done_b),
        .o_tick(tick_b), .o_bcd(bcd_b), .o_seg(seg_b)
    );

    stopwatch_ctrl #(
        .CLK_PER_TICK(2), .NUM_DIGITS(2), .TARGET(0), .DONE_TICKS(1), .LZ_BLANK(1)
    ) u_dut_c (
        .clk(clk), .reset_n(reset_n),
        .i_start(start_c), .i_pause(pause_c), .i_clear(clear_c),
        .o_idle(idle_c), .o_running(running_c), .o_paused(paused_c), .o_done(done_c),
        .o_tick(tick_c), .o_bcd(bcd_c), .o_seg(seg_c)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          cyc;
        logic [15:0] bcd;
        logic [3:0]  flags;
    } exp_t;
    exp_t sb[$];

    logic done_b_seen = 1'b0;
    always @(negedge clk) if (done_b) done_b_seen = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic [15:0] b, input logic [3:0] f);
        exp_t e;
        e.cyc   = c;
        e.bcd   = b;
        e.flags = f;
        sb.push_back(e);
    endtask

    // Monitor: every tick on instance A is matched against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && tick_a) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_tick: tick at cycle %0d bcd=%h, expected no tick", cyc, bcd_a);
            end else begin
                e = sb.pop_front();
                check("tick_cycle", cyc, e.cyc);
                check("tick_bcd", {16'h0, bcd_a}, {16'h0, e.bcd});
                check("tick_flags", {28'h0, flags_a}, {28'h0, e.flags});
                $display("tick cyc=%0d bcd=%h flags=%b", cyc, bcd_a, flags_a);
            end
        end
    end

    // Called in negedge context; returns at the negedge following posedge n.
    task automatic at_neg(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic pulse_a(input int n, input logic s, input logic p, input logic c);
        at_neg(n - 1);
        check("sched_a", cyc, n - 1);
        start_a = s; pause_a = p; clear_a = c;
        @(negedge clk);
        start_a = 1'b0; pause_a = 1'b0; clear_a = 1'b0;
    endtask

    int e, r;

    initial begin
        reset_n = 1'b0;
        start_a = 0; pause_a = 0; clear_a = 0;
        start_b = 0; pause_b = 0; clear_b = 0;
        start_c = 0; pause_c = 0; clear_c = 0;
        repeat (3) @(negedge clk);

        check("rst_flags", {28'h0, flags_a}, {28'h0, F_IDLE});
        check("rst_tick", {31'h0, tick_a}, 32'h0);
        check("rst_bcd", {16'h0, bcd_a}, 32'h0);
        check("rst_seg", {4'h0, seg_a}, 32'h0FFF_FFFF);

        reset_n = 1'b1;
        @(negedge clk);
        check("seg_after_rst_a", {4'h0, seg_a}, {4'h0, SEG_0, SEG_0, SEG_0, SEG_0});
        check("seg_after_rst_b", {18'h0, seg_b}, {18'h0, SEG_0, SEG_0});
        check("seg_after_rst_c", {18'h0, seg_c}, {18'h0, SEG_BLANK, SEG_0});

        // Plain run to target, DONE for one tick, back to IDLE holding 5.
        e = cyc + 1;
        for (int k = 1; k <= 4; k++) push(e + 10 * k, 16'(k), F_RUN);
        push(e + 50, 16'h5, F_DONE);
        push(e + 60, 16'h5, F_IDLE);
        pulse_a(e, 1, 0, 0);
        check("start_running", {28'h0, flags_a}, {28'h0, F_RUN});
        at_neg(e + 49);
        check("pre_done_bcd", {16'h0, bcd_a}, 32'h4);
        at_neg(e + 59);
        check("done_hold", {28'h0, flags_a}, {28'h0, F_DONE});
        at_neg(e + 65);
        check("idle_after_done", {28'h0, flags_a}, {28'h0, F_IDLE});
        check("final_bcd_held", {16'h0, bcd_a}, 32'h5);
        check("final_seg", {4'h0, seg_a}, {4'h0, SEG_0, SEG_0, SEG_0, SEG_5});

        // Pause at prescaler 6 for 37 clocks, then resume.
        e = cyc + 2;
        push(e + 10, 16'h1, F_RUN);
        push(e + 20, 16'h2, F_RUN);
        pulse_a(e, 1, 0, 0);
        pulse_a(e + 27, 0, 1, 0);
        check("paused_flags", {28'h0, flags_a}, {28'h0, F_PAUSE});
        r = e + 27 + 37;
        at_neg(r - 2);
        check("pause_frozen_bcd", {16'h0, bcd_a}, 32'h2);
        push(r + 3, 16'h3, F_RUN);
        push(r + 13, 16'h4, F_RUN);
        push(r + 23, 16'h5, F_DONE);
        push(r + 33, 16'h5, F_IDLE);
        pulse_a(r, 0, 1, 0);
        check("resumed_flags", {28'h0, flags_a}, {28'h0, F_RUN});
        at_neg(r + 40);

        // Final tick coinciding with pause goes to DONE.
        e = cyc + 2;
        for (int k = 1; k <= 4; k++) push(e + 10 * k, 16'(k), F_RUN);
        push(e + 50, 16'h5, F_DONE);
        push(e + 60, 16'h5, F_IDLE);
        pulse_a(e, 1, 0, 0);
        pulse_a(e + 50, 0, 1, 0);
        check("tick_pause_done", {28'h0, flags_a}, {28'h0, F_DONE});
        at_neg(e + 62);

        // Clear together with start aborts to IDLE with zero count.
        e = cyc + 2;
        push(e + 10, 16'h1, F_RUN);
        push(e + 20, 16'h2, F_RUN);
        pulse_a(e, 1, 0, 0);
        pulse_a(e + 25, 1, 0, 1);
        check("clear_start_flags", {28'h0, flags_a}, {28'h0, F_IDLE});
        check("clear_start_bcd", {16'h0, bcd_a}, 32'h0);
        at_neg(e + 45);

        // Free-run wrap 99 -> 00 on instance B.
        e = cyc + 2;
        at_neg(e - 1);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        at_neg(e + 180);
        check("b_bcd_90", {24'h0, bcd_b}, 32'h90);
        at_neg(e + 181);
        check("b_seg_90", {18'h0, seg_b}, {18'h0, SEG_9, SEG_0});
        at_neg(e + 198);
        check("b_bcd_99", {24'h0, bcd_b}, 32'h99);
        at_neg(e + 199);
        check("b_seg_99", {18'h0, seg_b}, {18'h0, SEG_9, SEG_9});
        at_neg(e + 200);
        check("b_bcd_wrap", {24'h0, bcd_b}, 32'h0);
        check("b_tick_wrap", {31'h0, tick_b}, 32'h1);
        check("b_running", {31'h0, running_b}, 32'h1);

        // Leading-zero blanking on instance C.
        e = cyc + 2;
        at_neg(e - 1);
        start_c = 1'b1;
        @(negedge clk);
        start_c = 1'b0;
        at_neg(e + 14);
        check("c_bcd_7", {24'h0, bcd_c}, 32'h07);
        at_neg(e + 15);
        check("c_seg_7", {18'h0, seg_c}, {18'h0, SEG_BLANK, SEG_7});
        at_neg(e + 20);
        check("c_bcd_10", {24'h0, bcd_c}, 32'h10);
        at_neg(e + 21);
        check("c_seg_10", {18'h0, seg_c}, {18'h0, SEG_1, SEG_0});

        // Asynchronous reset in the middle of a run.
        e = cyc + 2;
        push(e + 10, 16'h1, F_RUN);
        push(e + 20, 16'h2, F_RUN);
        push(e + 30, 16'h3, F_RUN);
        pulse_a(e, 1, 0, 0);
        at_neg(e + 33);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_flags", {28'h0, flags_a}, {28'h0, F_IDLE});
        check("midrst_bcd", {16'h0, bcd_a}, 32'h0);
        check("midrst_seg", {4'h0, seg_a}, 32'h0FFF_FFFF);
        check("midrst_tick", {31'h0, tick_a}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        check("scoreboard_empty", sb.size(), 32'h0);
        check("b_never_done", {31'h0, done_b_seen}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
